// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST sequence source: FSM state encoding,
// packet counter width and a clog2 helper that never returns less than 1.
package avalon_st_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int PKT_CNT_W = 16;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/avalon_st_seq_source_if.sv
// Avalon-ST source/sink handshake bundle. The channel signal exists only when
// AVST_SEQ_CHANNEL_EN is defined.
interface avalon_st_seq_source_if #(
    parameter int DATA_W = 8
`ifdef AVST_SEQ_CHANNEL_EN
    , parameter int CH_W = 1
`endif
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              ready;
`ifdef AVST_SEQ_CHANNEL_EN
    logic [CH_W-1:0]   channel;
`endif

    modport master (
        output valid, data, sop, eop,
`ifdef AVST_SEQ_CHANNEL_EN
        output channel,
`endif
        input  ready
    );

    modport slave (
        input  valid, data, sop, eop,
`ifdef AVST_SEQ_CHANNEL_EN
        input  channel,
`endif
        output ready
    );
endinterface

// File: rtl/avst_seq_counter.sv
// Beat index and inter-packet gap counter with terminal-count flags.
module avst_seq_counter
    import avalon_st_pkg::*;
#(
    parameter int SEQ_LEN    = 3,
    parameter int GAP_CYCLES = 0,
    localparam int IDX_W     = clog2_min1(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             idx_clr,
    input  logic             idx_inc,
    input  logic             gap_run,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             gap_done
);
    localparam int GAP_W = clog2_min1(GAP_CYCLES);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    always_comb begin
        idx_d = idx_q;
        if (idx_clr)      idx_d = '0;
        else if (idx_inc) idx_d = idx_q + IDX_W'(1);
    end

    // Gap counter runs from 0 while in GAP and self-clears on its terminal count.
    always_comb begin
        gap_d = '0;
        if (gap_run && !gap_done) gap_d = gap_q + GAP_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
            gap_q <= '0;
        end else begin
            idx_q <= idx_d;
            gap_q <= gap_d;
        end
    end

    assign idx      = idx_q;
    assign idx_last = (idx_q == IDX_W'(SEQ_LEN - 1));
    assign gap_done = (gap_q == GAP_W'(GAP_CYCLES - 1));

endmodule

// File: rtl/avalon_st_seq_source.sv
// Avalon-ST arithmetic sequence packet source with SOP/EOP framing, gap and continuous mode.
// Optional channel output enabled by defining AVST_SEQ_CHANNEL_EN.
module avalon_st_seq_source
    import avalon_st_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SEQ_LEN    = 3,
    parameter int START_VAL  = 4,
    parameter int STEP       = 1,
    parameter int GAP_CYCLES = 0,
    parameter int NUM_CH     = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 continuous,
    avalon_st_seq_source_if.master st,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    localparam int IDX_W = clog2_min1(SEQ_LEN);
    localparam logic [DATA_W-1:0] START_D = DATA_W'(START_VAL);
    localparam logic [DATA_W-1:0] STEP_D  = DATA_W'(STEP);

    if (DATA_W < 1 || DATA_W > 64 || SEQ_LEN < 1 || NUM_CH < 1) begin : g_bad_param
        $error("avalon_st_seq_source: illegal parameter value");
    end

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [PKT_CNT_W-1:0]  pkt_q, pkt_d;
    logic                  idx_clr, idx_inc, gap_run;
    logic [IDX_W-1:0]      idx;
    logic                  idx_last, gap_done;
`ifdef AVST_SEQ_CHANNEL_EN
    localparam int CH_W = clog2_min1(NUM_CH);
    logic [CH_W-1:0]       ch_q, ch_d;
`endif

    avst_seq_counter #(
        .SEQ_LEN    (SEQ_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_counter (
        .clk      (clk),
        .resetn   (resetn),
        .idx_clr  (idx_clr),
        .idx_inc  (idx_inc),
        .gap_run  (gap_run),
        .idx      (idx),
        .idx_last (idx_last),
        .gap_done (gap_done)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pkt_d   = pkt_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        gap_run = 1'b0;
`ifdef AVST_SEQ_CHANNEL_EN
        ch_d    = ch_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = SEND;
                    idx_clr = 1'b1;
                    data_d  = START_D;
                end
            end
            SEND: begin
                if (st.ready) begin
                    if (idx_last) begin
                        pkt_d   = pkt_q + PKT_CNT_W'(1);
                        idx_clr = 1'b1;
                        data_d  = START_D;
`ifdef AVST_SEQ_CHANNEL_EN
                        ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
`endif
                        if (GAP_CYCLES > 0)  state_d = GAP;
                        else if (continuous) state_d = SEND;
                        else                 state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                        data_d  = data_q + STEP_D;
                    end
                end
            end
            GAP: begin
                gap_run = 1'b1;
                if (gap_done) state_d = continuous ? SEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            data_q  <= '0;
            pkt_q   <= '0;
`ifdef AVST_SEQ_CHANNEL_EN
            ch_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pkt_q   <= pkt_d;
`ifdef AVST_SEQ_CHANNEL_EN
            ch_q    <= ch_d;
`endif
        end
    end

    // Outputs decode register state only; ready never reaches them combinationally.
    assign st.valid  = (state_q == SEND);
    assign st.data   = (state_q == SEND) ? data_q : '0;
    assign st.sop    = (state_q == SEND) && (idx == '0);
    assign st.eop    = (state_q == SEND) && idx_last;
`ifdef AVST_SEQ_CHANNEL_EN
    assign st.channel = ch_q;
`endif
    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Directed, scoreboard-checked bench for avalon_st_seq_source (default and gapped/wrapping
// configurations, plus a single-beat packet instance).
module tb_avalon_st_seq_source;
    import avalon_st_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        int          ch;
    } beat_t;

    logic clk;
    logic resetn;
    logic start_a, cont_a, start_b, cont_b, start_c, cont_c;
    logic busy_a, busy_b, busy_c;
    logic [PKT_CNT_W-1:0] pkt_a, pkt_b, pkt_c;

    beat_t q_a[$];
    beat_t q_b[$];
    int sb_ch_a, sb_ch_b, exp_pkt_a, exp_pkt_b;
    int pass_cnt, fail_cnt, total_cnt;

`ifdef AVST_SEQ_CHANNEL_EN
    avalon_st_seq_source_if #(.DATA_W(8), .CH_W(2)) ifa ();
    avalon_st_seq_source_if #(.DATA_W(8), .CH_W(2)) ifb ();
    avalon_st_seq_source_if #(.DATA_W(4), .CH_W(2)) ifc ();
`else
    avalon_st_seq_source_if #(.DATA_W(8)) ifa ();
    avalon_st_seq_source_if #(.DATA_W(8)) ifb ();
    avalon_st_seq_source_if #(.DATA_W(4)) ifc ();
`endif

    avalon_st_seq_source #(
        .DATA_W(8), .SEQ_LEN(3), .START_VAL(4), .STEP(1), .GAP_CYCLES(0), .NUM_CH(4)
    ) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .continuous(cont_a),
        .st(ifa), .busy(busy_a), .pkt_count(pkt_a)
    );

    avalon_st_seq_source #(
        .DATA_W(8), .SEQ_LEN(3), .START_VAL(254), .STEP(1), .GAP_CYCLES(2), .NUM_CH(4)
    ) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .continuous(cont_b),
        .st(ifb), .busy(busy_b), .pkt_count(pkt_b)
    );

    avalon_st_seq_source #(
        .DATA_W(4), .SEQ_LEN(1), .START_VAL(19), .STEP(5), .GAP_CYCLES(0), .NUM_CH(4)
    ) dut_c (
        .clk(clk), .resetn(resetn), .start(start_c), .continuous(cont_c),
        .st(ifc), .busy(busy_c), .pkt_count(pkt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a();
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            b.data = 64'((4 + i) % 256);
            b.sop  = (i == 0);
            b.eop  = (i == 2);
            b.ch   = sb_ch_a;
            q_a.push_back(b);
        end
        sb_ch_a = (sb_ch_a + 1) % 4;
        exp_pkt_a++;
    endtask

    task automatic push_b();
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            b.data = 64'((254 + i) % 256);
            b.sop  = (i == 0);
            b.eop  = (i == 2);
            b.ch   = sb_ch_b;
            q_b.push_back(b);
        end
        sb_ch_b = (sb_ch_b + 1) % 4;
        exp_pkt_b++;
    endtask

    // Observe at the falling edge: any beat offered with ready high transfers next edge.
    task automatic cycle();
        beat_t b;
        @(negedge clk);
        if (resetn && ifa.valid && ifa.ready) begin
            chk("a_beat_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                b = q_a.pop_front();
                chk("a_data", 64'(ifa.data), b.data);
                chk("a_sop", 64'(ifa.sop), 64'(b.sop));
                chk("a_eop", 64'(ifa.eop), 64'(b.eop));
`ifdef AVST_SEQ_CHANNEL_EN
                chk("a_channel", 64'(ifa.channel), 64'(b.ch));
`endif
            end
        end
        if (resetn && ifb.valid && ifb.ready) begin
            chk("b_beat_expected", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                b = q_b.pop_front();
                chk("b_data", 64'(ifb.data), b.data);
                chk("b_sop", 64'(ifb.sop), 64'(b.sop));
                chk("b_eop", 64'(ifb.eop), 64'(b.eop));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        sb_ch_a = 0; sb_ch_b = 0; exp_pkt_a = 0; exp_pkt_b = 0;
        resetn = 1'b0;
        start_a = 0; cont_a = 0; start_b = 0; cont_b = 0; start_c = 0; cont_c = 0;
        ifa.ready = 1'b1; ifb.ready = 1'b1; ifc.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        chk("rst_valid_a", 64'(ifa.valid), 64'd0);
        chk("rst_data_a", 64'(ifa.data), 64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_pkt_a", 64'(pkt_a), 64'd0);
        chk("rst_valid_b", 64'(ifb.valid), 64'd0);
        cycle();
        chk("idle_valid_a", 64'(ifa.valid), 64'd0);

        // Single packet, ready held high
        push_a();
        start_a = 1;
        cycle();
        start_a = 0;
        chk("lat1_valid", 64'(ifa.valid), 64'd1);
        repeat (3) cycle();
        chk("p1_valid_after", 64'(ifa.valid), 64'd0);
        chk("p1_busy_after", 64'(busy_a), 64'd0);
        chk("p1_pkt", 64'(pkt_a), 64'(exp_pkt_a));

        // Backpressure on the second beat, with a start pulse that must be ignored
        push_a();
        start_a = 1;
        cycle();
        start_a = 0;
        cycle();
        ifa.ready = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(ifa.valid), 64'd1);
            chk("bp_data", 64'(ifa.data), 64'd5);
            chk("bp_eop", 64'(ifa.eop), 64'd0);
            start_a = (i == 1);
            cycle();
        end
        start_a = 0;
        ifa.ready = 1;
        chk("bp_data_accept", 64'(ifa.data), 64'd5);
        cycle();
        cycle();
        repeat (2) begin
            chk("bp_no_queued_start", 64'(ifa.valid), 64'd0);
            cycle();
        end
        chk("bp_pkt", 64'(pkt_a), 64'(exp_pkt_a));

        // Continuous, no gap: 9 beats without bubbles, then drop continuous
        repeat (3) push_a();
        cont_a = 1;
        cycle();
        for (int i = 0; i < 9; i++) begin
            if (i == 6) cont_a = 0;
            chk("cont_no_bubble", 64'(ifa.valid), 64'd1);
            cycle();
        end
        chk("cont_idle_after", 64'(ifa.valid), 64'd0);
        chk("cont_pkt", 64'(pkt_a), 64'(exp_pkt_a));

        // Gap and wrap: 254,255,0, two idle cycles, then 254 with sop
        repeat (2) push_b();
        cont_b = 1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("gap_beat_valid", 64'(ifb.valid), 64'd1);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            chk("gap_valid_low", 64'(ifb.valid), 64'd0);
            chk("gap_busy", 64'(busy_b), 64'd1);
            cycle();
        end
        chk("gap_restart_valid", 64'(ifb.valid), 64'd1);
        chk("gap_restart_sop", 64'(ifb.sop), 64'd1);
        cont_b = 0;
        repeat (3) cycle();
        chk("gap2_valid_low", 64'(ifb.valid), 64'd0);
        chk("gap2_busy", 64'(busy_b), 64'd1);
        repeat (2) cycle();
        chk("gap2_idle", 64'(busy_b), 64'd0);
        chk("gap_pkt", 64'(pkt_b), 64'(exp_pkt_b));

        // Single-beat packet with truncated start value
        start_c = 1;
        cycle();
        start_c = 0;
        chk("len1_valid", 64'(ifc.valid), 64'd1);
        chk("len1_data", 64'(ifc.data), 64'd3);
        chk("len1_sop", 64'(ifc.sop), 64'd1);
        chk("len1_eop", 64'(ifc.eop), 64'd1);
        cycle();
        chk("len1_valid_after", 64'(ifc.valid), 64'd0);
        chk("len1_pkt", 64'(pkt_c), 64'd1);

        // Asynchronous reset on the second beat abandons the packet
        push_a();
        start_a = 1;
        cycle();
        start_a = 0;
        cycle();
        chk("pre_rst_data", 64'(ifa.data), 64'd5);
        #2 resetn = 1'b0;
        #1;
        chk("async_valid", 64'(ifa.valid), 64'd0);
        chk("async_sop", 64'(ifa.sop), 64'd0);
        chk("async_eop", 64'(ifa.eop), 64'd0);
        chk("async_busy", 64'(busy_a), 64'd0);
        chk("async_pkt", 64'(pkt_a), 64'd0);
        q_a.delete();
        q_b.delete();
        sb_ch_a = 0; sb_ch_b = 0; exp_pkt_a = 0; exp_pkt_b = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) begin
            chk("post_rst_idle", 64'(ifa.valid), 64'd0);
            chk("post_rst_pkt", 64'(pkt_a), 64'd0);
            cycle();
        end

`ifdef AVST_SEQ_CHANNEL_EN
        // Five back-to-back packets: channel 0,1,2,3,0
        repeat (5) push_a();
        cont_a = 1;
        cycle();
        for (int i = 0; i < 15; i++) begin
            if (i == 12) cont_a = 0;
            chk("ch_no_bubble", 64'(ifa.valid), 64'd1);
            cycle();
        end
        chk("ch_pkt", 64'(pkt_a), 64'(exp_pkt_a));
        chk("ch_wrapped", 64'(ifa.channel), 64'd1);
`endif

        // Recovery packet after reset
        push_a();
        start_a = 1;
        cycle();
        start_a = 0;
        repeat (3) cycle();
        chk("recover_pkt", 64'(pkt_a), 64'(exp_pkt_a));
        chk("a_sb_drained", 64'(q_a.size()), 64'd0);
        chk("b_sb_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/avalon_st_seq_source.md
Name: avalon_st_seq_source

Overview:
- Parametrised Avalon-ST source; emits packets of an arithmetic data sequence (START_VAL, START_VAL+STEP, ...) under ready/valid backpressure.
- Next generation of the fixed 4/5/6 byte source: configurable width, length, start, step and inter-packet gap, with SOP/EOP framing.
- Supports single-shot and continuous modes.
- Sits in front of Avalon-ST sinks and FIFOs as a stimulus/pattern generator.

Parameters:
- DATA_W, 8, data bus width in bits (1..64).
- SEQ_LEN, 3, beats per packet (>=1).
- START_VAL, 4, data value of the first beat, truncated to DATA_W.
- STEP, 1, per-beat increment, modulo 2^DATA_W.
- GAP_CYCLES, 0, idle cycles inserted after each packet (0 = back-to-back).
- NUM_CH, 4, channel count, used only with AVST_SEQ_CHANNEL_EN.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request for one packet; sampled only in IDLE.
- continuous  in  1  when 1, a new packet begins after each packet and its gap, with no start needed.
- ready  in  1  sink ready, ready latency 0.
- valid  out  1  beat valid.
- data  out  DATA_W  beat data.
- sop  out  1  first beat of packet; qualified by valid.
- eop  out  1  last beat of packet; qualified by valid.
- busy  out  1  high in SEND or GAP.
- pkt_count  out  16  count of completed packets; wraps 0xFFFF->0.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, beat index idx=0, gap counter=0, pkt_count=0.
  - valid, sop, eop and busy go 0 immediately; data=0.
  - Reset mid-packet abandons the packet. No EOP is issued, and pkt_count is not incremented for it.
- Output timing:
  - All outputs are decoded from registers only.
  - No combinational path from ready to any output.
- States:
  - IDLE: valid=0, data=0.
    - start=1 or continuous=1 -> SEND, idx=0.
    - First beat is visible the next cycle (1-cycle latency).
  - SEND: valid=1, data=(START_VAL+idx*STEP) mod 2^DATA_W, sop=(idx==0), eop=(idx==SEQ_LEN-1).
  - Transfer: a beat transfers on a rising edge where valid&&ready.
    - Non-last beat: idx++.
    - Last beat: pkt_count++, idx=0, then:
      - GAP_CYCLES>0 -> GAP.
      - GAP_CYCLES=0 and continuous=1 -> stay in SEND; next packet's SOP beat appears the very next cycle.
      - Otherwise -> IDLE.
  - GAP: valid=0. Counts GAP_CYCLES cycles, then:
    - continuous=1 -> SEND.
    - Otherwise -> IDLE.
    - continuous is sampled on the final gap cycle.
- Backpressure:
  - While valid=1 and ready=0, data, sop and eop are held stable. idx does not advance.
  - valid never deasserts until the beat is accepted.
- Mode and start handling:
  - start while busy is ignored and not queued.
  - Dropping continuous mid-packet completes the current packet, then the block returns to IDLE.
- Arithmetic and edge cases:
  - Data wraps modulo 2^DATA_W; e.g. DATA_W=8, START_VAL=254, STEP=1 gives 254, 255, 0.
  - SEQ_LEN=1: sop and eop are both 1 on the single beat.
  - idx width is clog2(SEQ_LEN), minimum 1.

Optional Feature:
- Macro AVST_SEQ_CHANNEL_EN.
- Defined:
  - Adds output port channel, width clog2(NUM_CH) (minimum 1).
  - channel is constant for all beats of a packet.
  - After each completed packet it increments modulo NUM_CH. Reset value is 0.
  - Held stable under backpressure.
- Undefined: the port is absent; NUM_CH is unused.

Decomposition:
- Shared package avalon_st_pkg:
  - State encoding localparams: IDLE=2'd0, SEND=2'd1, GAP=2'd2.
  - Function clog2_min1.
  - Packet count width constant PKT_CNT_W=16.
- One natural sub-module, avst_seq_counter: beat index and gap counter with terminal-count flags.
- FSM and output decode stay in the top module.

Test Plan:
- Default params, one start pulse, ready=1: three beats with data 4, 5, 6 on consecutive cycles, starting 1 cycle after start. sop on 4, eop on 6; pkt_count=1; then IDLE, valid=0.
- Same, with ready=0 for 3 cycles on the beat with data 5: valid stays 1 and data stays 5 for all 4 cycles; then data=6 with eop.
- continuous=1, GAP_CYCLES=0, ready=1 for 9 cycles: data sequence 4, 5, 6, 4, 5, 6, 4, 5, 6 with no bubbles; pkt_count=3.
- DATA_W=8, START_VAL=254, STEP=1, SEQ_LEN=3, GAP_CYCLES=2, continuous=1: beats 254, 255, 0, then exactly 2 cycles with valid=0, then 254 with sop.
- Assert resetn=0 while valid=1 on the second beat: valid=0 in the same cycle. After release, stays IDLE with pkt_count=0 until start.
- With AVST_SEQ_CHANNEL_EN, NUM_CH=4, five back-to-back packets: channel values 0, 1, 2, 3, 0, each constant across its packet.
